count_monitor: RTL and testbench

Receive-side checker for the up/down counter's count bus. Samples a free-running count value and recovers the direction the counter is running (matching the counter's `select` encoding). It also flags wrap-around, detects illegal jumps, and reports lock once the sequence is consistent. It sits downstream of any counter instance, on a synchronous copy of its output, for self-check and status.

---
 rtl/count_monitor_pkg.sv | 27 ++
 rtl/count_delta_classify.sv | 40 ++++
 rtl/count_monitor.sv | 199 +++++++++++++++++++
 tb/tb_count_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the count_monitor receive-side checker.
// Direction encoding matches the up/down counter's select input.
package count_monitor_pkg;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    EMPTY,
    ACQ,
    LOCKED
  } state_e;

  // Classification of one qualified sample against the previous one.
  typedef enum logic [1:0] {
    HOLD,
    UP,
    DOWN,
    JUMP
  } delta_class_e;

  // Direction values, identical to the counter's select encoding.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Width of the consecutive-step run counter (LOCK_N is at most 15).
  localparam int RUN_W = 4;

endpackage : count_monitor_pkg

// File: rtl/count_delta_classify.sv
// Combinational classifier: compares the previous and current count values
// modulo 2^BITS and reports HOLD / UP / DOWN / JUMP plus a wrap flag for
// steps that cross the max <-> 0 boundary.
module count_delta_classify
  import count_monitor_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] prev,
  input  logic [BITS-1:0] count_in,
  output delta_class_e    cls,
  output logic            wrap
);

  localparam logic [BITS-1:0] ALL_ONES = '1;
  localparam logic [BITS-1:0] ONE      = BITS'(1);

  logic [BITS-1:0] delta;

  // Subtraction wraps naturally at BITS, giving delta mod 2^BITS.
  assign delta = count_in - prev;

  // Decode the delta into a class and flag boundary-crossing steps.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    cls  = JUMP;
    wrap = 1'b0;
    if (delta == '0) begin
      cls = HOLD;
    end else if (delta == ONE) begin
      cls = UP;
    end else if (delta == ALL_ONES) begin
      cls = DOWN;
    end
    wrap = ((cls == UP)   && (prev == ALL_ONES)) ||
           ((cls == DOWN) && (prev == '0));
  end

endmodule : count_delta_classify

// File: rtl/count_monitor.sv
// count_monitor: watches a counter's count bus, recovers its direction,
// pulses on legal steps, wrap-arounds and illegal jumps, and reports lock
// after LOCK_N consecutive same-direction steps.
// Optional statistics counters (up/down/jump) are built when the macro
// COUNT_MONITOR_STATS_EN is defined; they are absent otherwise.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int BITS   = 4,
  parameter int LOCK_N = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [BITS-1:0]   count_in,
  output logic              dir,
  output logic              locked,
  output logic              step,
  output logic              wrap,
  output logic              err
`ifdef COUNT_MONITOR_STATS_EN
  ,
  output logic [STAT_W-1:0] up_cnt,
  output logic [STAT_W-1:0] down_cnt,
  output logic [STAT_W-1:0] err_cnt
`endif
);

  // Reject configurations the run counter or classifier cannot handle.
  if (BITS < 2 || LOCK_N < 1 || LOCK_N > 15 || STAT_W < 1) begin : g_bad_param
    $error("count_monitor: illegal parameter combination");
  end

  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);

  state_e             state_q, state_d;
  logic [BITS-1:0]    prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               dir_q, dir_d;
  logic               locked_q, locked_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;

  delta_class_e       cls;
  logic               cls_wrap;
  logic               step_dir;

  count_delta_classify #(
    .BITS (BITS)
  ) u_classify (
    .prev     (prev_q),
    .count_in (count_in),
    .cls      (cls),
    .wrap     (cls_wrap)
  );

  assign step_dir = (cls == DOWN) ? DIR_DOWN : DIR_UP;

  // Next-state, run counter, direction and pulse decode for one sample.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (sample_en) begin
      prev_d = count_in;
      unique case (state_q)
        EMPTY: begin
          // First sample only seeds prev.
          state_d = ACQ;
          run_d   = '0;
        end
        ACQ: begin
          unique case (cls)
            UP, DOWN: begin
              step_d = 1'b1;
              wrap_d = cls_wrap;
              if ((run_q != '0) && (step_dir == dir_q)) begin
                run_d = run_q + RUN_W'(1);
              end else begin
                // Fresh run or reversal: restart counting in the new direction.
                dir_d = step_dir;
                run_d = RUN_W'(1);
              end
              if (run_d == LOCK_RUN) begin
                state_d = LOCKED;
              end
            end
            JUMP: begin
              err_d = 1'b1;
              run_d = '0;
            end
            default: ;
          endcase
        end
        LOCKED: begin
          unique case (cls)
            UP, DOWN: begin
              // Reversals are legal once locked; direction just follows.
              step_d = 1'b1;
              wrap_d = cls_wrap;
              dir_d  = step_dir;
            end
            JUMP: begin
              err_d   = 1'b1;
              run_d   = '0;
              state_d = ACQ;
            end
            default: ;
          endcase
        end
        default: begin
          state_d = EMPTY;
          run_d   = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs; everything clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= EMPTY;
      prev_q   <= '0;
      run_q    <= '0;
      dir_q    <= DIR_UP;
      locked_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
    end
  end

  assign dir    = dir_q;
  assign locked = locked_q;
  assign step   = step_q;
  assign wrap   = wrap_q;
  assign err    = err_q;

`ifdef COUNT_MONITOR_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] up_cnt_q, up_cnt_d;
  logic [STAT_W-1:0] down_cnt_q, down_cnt_d;
  logic [STAT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating event counters, advanced alongside their matching pulses.
  always_comb begin
    up_cnt_d   = up_cnt_q;
    down_cnt_d = down_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (step_d && (cls == UP) && (up_cnt_q != STAT_MAX)) begin
      up_cnt_d = up_cnt_q + STAT_W'(1);
    end
    if (step_d && (cls == DOWN) && (down_cnt_q != STAT_MAX)) begin
      down_cnt_d = down_cnt_q + STAT_W'(1);
    end
    if (err_d && (err_cnt_q != STAT_MAX)) begin
      err_cnt_d = err_cnt_q + STAT_W'(1);
    end
  end

  // Statistics registers; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_cnt_q   <= '0;
      down_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      up_cnt_q   <= up_cnt_d;
      down_cnt_q <= down_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign up_cnt   = up_cnt_q;
  assign down_cnt = down_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule : count_monitor

// File: tb/tb_count_monitor.sv
// Self-checking bench for count_monitor (BITS=4, LOCK_N=4). A behavioural
// reference model pushes the expected outputs into a scoreboard queue each
// time a sample is driven; the entry is popped and compared once the
// registered outputs have settled after the clock edge.
module tb_count_monitor;

  localparam int BITS   = 4;
  localparam int LOCK_N = 4;
  localparam int STAT_W = 16;
  localparam int MODV   = 1 << BITS;
  localparam int MAXV   = MODV - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_en = 1'b0;
  logic [BITS-1:0]  count_in = '0;
  logic             dir, locked, step, wrap, err;
`ifdef COUNT_MONITOR_STATS_EN
  logic [STAT_W-1:0] up_cnt, down_cnt, err_cnt;
`endif

  count_monitor #(
    .BITS   (BITS),
    .LOCK_N (LOCK_N),
    .STAT_W (STAT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .count_in  (count_in),
    .dir       (dir),
    .locked    (locked),
    .step      (step),
    .wrap      (wrap),
    .err       (err)
`ifdef COUNT_MONITOR_STATS_EN
    ,
    .up_cnt    (up_cnt),
    .down_cnt  (down_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dir;
    logic locked;
    logic step;
    logic wrap;
    logic err;
    int   up;
    int   dn;
    int   ec;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  // Reference model state: 0 = empty, 1 = acquiring, 2 = locked.
  int    m_state, m_prev, m_run, m_up, m_dn, m_ec;
  logic  m_dir;

  // Observed pulse tallies, cleared per test phase.
  int    step_seen, wrap_seen, err_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s got=%0d expected=%0d @%0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_run = 0; m_dir = 1'b0;
    m_up = 0; m_dn = 0; m_ec = 0;
  endtask

  // Advance the model by one cycle and queue the outputs expected after it.
  task automatic model_push(input logic en, input int val);
    exp_t e;
    int   d;
    logic down;
    e.step = 1'b0; e.wrap = 1'b0; e.err = 1'b0;
    if (en) begin
      d = (val - m_prev + MODV) % MODV;
      if (m_state == 0) begin
        m_state = 1;
        m_run   = 0;
      end else if (d == 1 || d == MAXV) begin
        down   = (d == MAXV);
        e.step = 1'b1;
        e.wrap = down ? (val == MAXV) : (val == 0);
        if (down) m_dn++; else m_up++;
        if (m_state == 1) begin
          if (m_run > 0 && down == m_dir) m_run++;
          else begin
            m_dir = down;
            m_run = 1;
          end
          if (m_run >= LOCK_N) m_state = 2;
        end else begin
          m_dir = down;
        end
      end else if (d != 0) begin
        e.err   = 1'b1;
        m_ec++;
        m_run   = 0;
        m_state = 1;
      end
      m_prev = val;
    end
    e.dir = m_dir; e.locked = (m_state == 2);
    e.up = m_up; e.dn = m_dn; e.ec = m_ec;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("dir",    dir,    e.dir);
    check("locked", locked, e.locked);
    check("step",   step,   e.step);
    check("wrap",   wrap,   e.wrap);
    check("err",    err,    e.err);
`ifdef COUNT_MONITOR_STATS_EN
    check("up_cnt",   up_cnt,   e.up);
    check("down_cnt", down_cnt, e.dn);
    check("err_cnt",  err_cnt,  e.ec);
`endif
    if (step === 1'b1) step_seen++;
    if (wrap === 1'b1) wrap_seen++;
    if (err  === 1'b1) err_seen++;
  endtask

  // Drive one cycle of stimulus, then compare after the edge.
  task automatic drive(input logic en, input int val);
    @(negedge clk);
    sample_en = en;
    count_in  = BITS'(val);
    model_push(en, val);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".dir"},    dir,    1'b0);
    check({tag, ".locked"}, locked, 1'b0);
    check({tag, ".step"},   step,   1'b0);
    check({tag, ".wrap"},   wrap,   1'b0);
    check({tag, ".err"},    err,    1'b0);
`ifdef COUNT_MONITOR_STATS_EN
    check({tag, ".up_cnt"},   up_cnt,   0);
    check({tag, ".down_cnt"}, down_cnt, 0);
    check({tag, ".err_cnt"},  err_cnt,  0);
`endif
  endtask

  // Assert reset mid-cycle (asynchronously), check, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    sample_en = 1'b1;
    #1;
    check_all_zero("rst_async");
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    sample_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_seq(input int vals[]);
    foreach (vals[i]) drive(1'b1, vals[i]);
  endtask

  initial begin
    int r, v;
    model_reset();
    step_seen = 0; wrap_seen = 0; err_seen = 0;

    phase = "reset";
    do_reset();

    // Acquire lock on an up-count.
    phase = "lock";
    step_seen = 0;
    run_seq('{3, 4, 5, 6, 7});
    check("steps", step_seen, 4);
    check("locked_now", locked, 1'b1);
    check("dir_up", dir, 1'b0);

    // Wrap from max to zero while locked.
    phase = "wrap";
    run_seq('{8, 9, 10, 11, 12, 13});
    wrap_seen = 0; err_seen = 0;
    run_seq('{14, 15, 0, 1});
    check("wrap_pulses", wrap_seen, 1);
    check("err_pulses", err_seen, 0);

    // Reversal while locked keeps lock.
    phase = "reverse";
    run_seq('{2, 3, 4, 5});
    step_seen = 0;
    drive(1'b1, 4);
    check("dir_down", dir, 1'b1);
    check("still_locked", locked, 1'b1);
    drive(1'b1, 3);
    check("steps", step_seen, 2);

    // Illegal jump drops lock; re-acquire.
    phase = "jump";
    run_seq('{4, 5});
    drive(1'b1, 9);
    check("err_now", err, 1'b1);
    check("unlocked", locked, 1'b0);
    run_seq('{10, 11, 12});
    check("not_yet", locked, 1'b0);
    drive(1'b1, 13);
    check("relocked", locked, 1'b1);

    // Qualifier low: nothing happens however count_in moves.
    phase = "gap";
    step_seen = 0; wrap_seen = 0; err_seen = 0;
    for (int i = 0; i < 10; i++) drive(1'b0, int'($urandom_range(0, MAXV)));
    check("no_steps", step_seen, 0);
    check("no_errs", err_seen, 0);
    drive(1'b1, 14);
    check("resume_step", step, 1'b1);

    // Reset in the middle of acquisition.
    phase = "rst_mid";
    do_reset();
    run_seq('{3, 4, 5});
    check("acq_not_locked", locked, 1'b0);
    do_reset();

    // Statistics sequence: 3 up, 2 down, 1 jump.
    phase = "stats";
    run_seq('{0, 1, 2, 3, 2, 1, 9});
`ifdef COUNT_MONITOR_STATS_EN
    check("up_total", up_cnt, 3);
    check("down_total", down_cnt, 2);
    check("err_total", err_cnt, 1);
`endif

    // Mostly-legal random stream with gaps, holds, reversals and jumps.
    phase = "random";
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 7));
      case (r)
        0, 1, 2, 6: v = (m_prev + 1) % MODV;
        3, 7:       v = (m_prev + MAXV) % MODV;
        4:          v = m_prev;
        default:    v = int'($urandom_range(0, MAXV));
      endcase
      drive($urandom_range(0, 3) != 0, v);
    end

    phase = "end";
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule : tb_count_monitor
